// File: rtl/herculesae_vx_pdiv_if.sv
// -----------------------------------------------------------------------------
// herculesae_vx_pdiv_if
// Request/response bundle for the GF(2) polynomial divider.
//   ival        requester -> divider  request valid (taken only while ready=1)
//   dividend_in requester -> divider  128-bit dividend, bit i = coeff of x^i
//   divisor_in  requester -> divider  low 64 coeffs of monic divisor x^64 + d
//   ready       divider -> requester  a request can be accepted this cycle
//   oval        divider -> requester  one-cycle pulse, quot_q/rem_q valid
//   quot_q      divider -> requester  64-bit quotient, registered
//   rem_q       divider -> requester  64-bit remainder, registered
// -----------------------------------------------------------------------------
interface herculesae_vx_pdiv_if;
   logic         ival;
   logic [127:0] dividend_in;
   logic [63:0]  divisor_in;
   logic         ready;
   logic         oval;
   logic [63:0]  quot_q;
   logic [63:0]  rem_q;

   modport master (
      output ival, dividend_in, divisor_in,
      input  ready, oval, quot_q, rem_q
   );

   modport slave (
      input  ival, dividend_in, divisor_in,
      output ready, oval, quot_q, rem_q
   );
endinterface

// File: rtl/herculesae_vx_pdiv.sv
// -----------------------------------------------------------------------------
// herculesae_vx_pdiv
// Sequential carry-less (GF(2)) polynomial divider, the inverse of the 64x64
// PMULL array. Divides a 128-bit dividend by the monic divisor x^64 + d and
// returns a 64-bit quotient and 64-bit remainder, so that
//   pmull(quot, d) ^ (quot << 64) ^ rem == dividend.
// BITS_PER_CYCLE quotient bits are resolved per RUN cycle (legal: 1,2,4,8,16).
//
// Ports:
//   clk    single clock, all state updates on posedge
//   reset  synchronous, active-high; has priority over a simultaneous ival
//   bus    herculesae_vx_pdiv_if.slave (ival/dividend_in/divisor_in in,
//          ready/oval/quot_q/rem_q out)
//
// Optional build macro:
//   HERCULESAE_PDIV_EARLY_EXIT_EN  when defined, a dividend whose upper 64
//   bits are zero skips RUN: quotient 0, remainder = dividend[63:0], oval one
//   cycle after accept. When undefined every op takes NUM_STEPS+1 cycles.
// -----------------------------------------------------------------------------
module herculesae_vx_pdiv #(
   parameter int BITS_PER_CYCLE = 4
) (
   input  logic clk,
   input  logic reset,
   herculesae_vx_pdiv_if.slave bus
);

   localparam int NUM_STEPS = 64 / BITS_PER_CYCLE;
   localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [127:0]       work;
   logic [127:0]       work_nxt;
   logic [63:0]        div;
   logic [63:0]        quot;
   logic [63:0]        quot_nxt;
   logic [63:0]        quot_q;
   logic [63:0]        rem_q;
   logic               ready;
   logic               oval;
   logic               accept;
   logic               last_step;
   logic               fast_path;

   // ---------------------------------------------------------------------------
   // One RUN cycle worth of long-division steps, MSB first. The x^127 term is
   // cancelled by the implicit x^64 of the divisor, so only d lands in
   // work[126:63] before the shift.
   // ---------------------------------------------------------------------------
   always_comb begin : step_chain
      work_nxt = work;
      quot_nxt = quot;
      // NOTE: blocking assignments here are deliberate -- each loop iteration
      // must see the previous step's result within the same cycle.
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (work_nxt[127]) begin
            work_nxt[126:63] = work_nxt[126:63] ^ div;
         end
         quot_nxt = {quot_nxt[62:0], work_nxt[127]};
         work_nxt = work_nxt << 1;
      end
   end

   assign last_step = (state == S_RUN) && (cnt == LAST_CNT);
   assign accept    = ready && bus.ival;

`ifdef HERCULESAE_PDIV_EARLY_EXIT_EN
   assign fast_path = (bus.dividend_in[127:64] == 64'd0);
`else
   assign fast_path = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // FSM: state register + next-state/output decode
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: state and control registers use non-blocking assignments so
      // every flop samples pre-edge values regardless of block ordering.
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin : fsm_decode
      state_nxt = state;
      ready     = 1'b0;
      oval      = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (bus.ival) begin
               state_nxt = fast_path ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (last_step) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            // Results were loaded on entry, so oval and the data line up here;
            // a new request is taken in the same cycle for back-to-back ops.
            ready = 1'b1;
            oval  = 1'b1;
            if (bus.ival) begin
               state_nxt = fast_path ? S_DONE : S_RUN;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Step counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= '0;
      end else if (state == S_RUN) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Working registers
   // ---------------------------------------------------------------------------
   // NOTE: no reset on the working registers -- they are always loaded at
   // accept before they are read, and leaving them unreset keeps them off the
   // reset tree.
   always_ff @(posedge clk) begin
      if (accept) begin
         work <= bus.dividend_in;
         div  <= bus.divisor_in;
      end else if (state == S_RUN) begin
         work <= work_nxt;
         quot <= quot_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Result registers: loaded on the edge entering DONE, held until next DONE
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         quot_q <= '0;
         rem_q  <= '0;
      end else if (accept && fast_path) begin
         quot_q <= '0;
         rem_q  <= bus.dividend_in[63:0];
      end else if (last_step) begin
         quot_q <= quot_nxt;
         rem_q  <= work_nxt[127:64];
      end
   end

   assign bus.ready  = ready;
   assign bus.oval   = oval;
   assign bus.quot_q = quot_q;
   assign bus.rem_q  = rem_q;

endmodule
